// File: rtl/conditional_unit_vec.sv
// Purpose : per-lane ARM condition evaluation, NZCV flag registers, and the E->M control register.
// Latency : CondExE/BranchTakenE combinational (0 cycles); M-stage controls and flags 1 cycle.
// Backpressure: stall_i holds the M register and blocks flag writes; flush_i clears M (wins over stall).
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   stall_i, flush_i  pipeline hold / kill of the instruction in E
//   valid_e, vec_mode, br_reduce, lane_mask_e   instruction qualifiers and lane control
//   PCSrcE, RegWriteE, MemWriteE, BranchE, FlagWriteE, CondE   decoded controls from E
//   ALUFlags          per-lane NZCV from the ALU, lane i at [4i+3:4i]
//   FlagsQ            registered per-lane NZCV, same packing
//   CondExE, BranchTakenE   combinational per-lane condition result and branch decision
//   lane_en_m, PCSrcM, RegWriteM, MemWriteM, valid_m   registered M-stage controls
module conditional_unit_vec #(
  parameter int unsigned LANES    = 4,
  parameter logic [3:0]  FLAG_RST = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 valid_e,
  input  logic                 vec_mode,
  input  logic                 br_reduce,
  input  logic                 PCSrcE,
  input  logic                 RegWriteE,
  input  logic                 MemWriteE,
  input  logic                 BranchE,
  input  logic [1:0]           FlagWriteE,
  input  logic [3:0]           CondE,
  input  logic [LANES-1:0]     lane_mask_e,
  input  logic [4*LANES-1:0]   ALUFlags,
  output logic [4*LANES-1:0]   FlagsQ,
  output logic [LANES-1:0]     CondExE,
  output logic                 BranchTakenE,
  output logic [LANES-1:0]     lane_en_m,
  output logic                 PCSrcM,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 valid_m
);

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;

  // Flag order inside a lane nibble is {N,Z,C,V}.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic res;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      CC_EQ:   res = z;
      CC_NE:   res = ~z;
      CC_CS:   res = c;
      CC_CC:   res = ~c;
      CC_MI:   res = n;
      CC_PL:   res = ~n;
      CC_VS:   res = v;
      CC_VC:   res = ~v;
      CC_HI:   res = c & ~z;
      CC_LS:   res = ~c | z;
      CC_GE:   res = (n == v);
      CC_LT:   res = (n != v);
      CC_GT:   res = ~z & (n == v);
      CC_LE:   res = z | (n != v);
      CC_AL:   res = 1'b1;
      default: res = 1'b0; // 4'hF is reserved and never executes
    endcase
    return res;
  endfunction

  logic [LANES-1:0][3:0] flags_q, flags_d;
  logic [LANES-1:0][3:0] alu_l;
  logic [LANES-1:0]      lane_act;
  logic [LANES-1:0]      lane_en_m_q, lane_en_m_d;
  logic                  pcsrc_m_q, pcsrc_m_d;
  logic                  regwrite_m_q, regwrite_m_d;
  logic                  memwrite_m_q, memwrite_m_d;
  logic                  valid_m_q, valid_m_d;
  logic                  vec_eff;
  logic                  any_act;
  logic                  all_act;
  logic                  red;
  logic                  wr_ok;

  assign alu_l = ALUFlags;

  // A single-lane build has nothing to vectorise, so it always runs the scalar rules.
  assign vec_eff = vec_mode & (LANES > 1);

  always_comb begin
    CondExE  = '0;
    lane_act = '0;
    for (int i = 0; i < LANES; i++) begin
      CondExE[i] = cond_eval(CondE, flags_q[i]);
      if (vec_eff) begin
        lane_act[i] = valid_e & lane_mask_e[i] & CondExE[i];
      end else if (i == 0) begin
        lane_act[i] = valid_e & CondExE[i];
      end
    end
  end

  // ALL-reduction only looks at masked lanes; an empty mask must not count as "all true".
  always_comb begin
    any_act = |lane_act;
    all_act = (|lane_mask_e) & (&(lane_act | ~lane_mask_e));
    if (!vec_eff) begin
      red = CondExE[0];
    end else if (br_reduce) begin
      red = all_act;
    end else begin
      red = any_act;
    end
    BranchTakenE = BranchE & valid_e & ~flush_i & red;
  end

  // NZ and CV groups are written independently; a stalled or flushed instruction never commits flags.
  always_comb begin
    wr_ok   = ~stall_i & ~flush_i;
    flags_d = flags_q;
    for (int i = 0; i < LANES; i++) begin
      if (FlagWriteE[1] & lane_act[i] & wr_ok) begin
        flags_d[i][3:2] = alu_l[i][3:2];
      end
      if (FlagWriteE[0] & lane_act[i] & wr_ok) begin
        flags_d[i][1:0] = alu_l[i][1:0];
      end
    end
  end

  // M-stage next state: flush clears, stall holds, otherwise capture the gated controls.
  always_comb begin
    lane_en_m_d  = lane_en_m_q;
    pcsrc_m_d    = pcsrc_m_q;
    regwrite_m_d = regwrite_m_q;
    memwrite_m_d = memwrite_m_q;
    valid_m_d    = valid_m_q;
    if (flush_i) begin
      lane_en_m_d  = '0;
      pcsrc_m_d    = 1'b0;
      regwrite_m_d = 1'b0;
      memwrite_m_d = 1'b0;
      valid_m_d    = 1'b0;
    end else if (!stall_i) begin
      lane_en_m_d  = lane_act;
      pcsrc_m_d    = PCSrcE & (vec_eff ? red : lane_act[0]);
      regwrite_m_d = RegWriteE & any_act;
      memwrite_m_d = MemWriteE & any_act;
      valid_m_d    = valid_e;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q      <= {LANES{FLAG_RST}};
      lane_en_m_q  <= '0;
      pcsrc_m_q    <= 1'b0;
      regwrite_m_q <= 1'b0;
      memwrite_m_q <= 1'b0;
      valid_m_q    <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      lane_en_m_q  <= lane_en_m_d;
      pcsrc_m_q    <= pcsrc_m_d;
      regwrite_m_q <= regwrite_m_d;
      memwrite_m_q <= memwrite_m_d;
      valid_m_q    <= valid_m_d;
    end
  end

  assign FlagsQ    = flags_q;
  assign lane_en_m = lane_en_m_q;
  assign PCSrcM    = pcsrc_m_q;
  assign RegWriteM = regwrite_m_q;
  assign MemWriteM = memwrite_m_q;
  assign valid_m   = valid_m_q;

endmodule

// File: tb/tb_conditional_unit_vec.sv
module tb_conditional_unit_vec;

  localparam int LANES = 4;
  localparam logic [3:0] FLAG_RST = 4'b0100;

  logic clk = 1'b0;
  logic rst;
  logic stall_i, flush_i, valid_e, vec_mode, br_reduce;
  logic PCSrcE, RegWriteE, MemWriteE, BranchE;
  logic [1:0] FlagWriteE;
  logic [3:0] CondE;
  logic [LANES-1:0] lane_mask_e;
  logic [4*LANES-1:0] ALUFlags;
  logic [4*LANES-1:0] FlagsQ;
  logic [LANES-1:0] CondExE;
  logic BranchTakenE;
  logic [LANES-1:0] lane_en_m;
  logic PCSrcM, RegWriteM, MemWriteM, valid_m;

  conditional_unit_vec #(.LANES(LANES), .FLAG_RST(FLAG_RST)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_e(valid_e),
    .vec_mode(vec_mode), .br_reduce(br_reduce), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .FlagWriteE(FlagWriteE), .CondE(CondE),
    .lane_mask_e(lane_mask_e), .ALUFlags(ALUFlags), .FlagsQ(FlagsQ), .CondExE(CondExE),
    .BranchTakenE(BranchTakenE), .lane_en_m(lane_en_m), .PCSrcM(PCSrcM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .valid_m(valid_m)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: per-lane flags and the expected M bundle {lane_en, PCSrc, RegWrite, MemWrite, valid}.
  logic [3:0] mf [LANES];
  logic [LANES+3:0] mm;
  logic [LANES+3:0] sb [$];
  logic [LANES+3:0] e;
  wire  [LANES+3:0] m_vec = {lane_en_m, PCSrcM, RegWriteM, MemWriteM, valid_m};

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    case (c)
      4'h0: return f[2];
      4'h1: return !f[2];
      4'h2: return f[1];
      4'h3: return !f[1];
      4'h4: return f[3];
      4'h5: return !f[3];
      4'h6: return f[0];
      4'h7: return !f[0];
      4'h8: return f[1] && !f[2];
      4'h9: return !f[1] || f[2];
      4'hA: return f[3] == f[0];
      4'hB: return f[3] != f[0];
      4'hC: return !f[2] && (f[3] == f[0]);
      4'hD: return f[2] || (f[3] != f[0]);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [LANES-1:0] ref_condex();
    logic [LANES-1:0] r;
    for (int i = 0; i < LANES; i++) r[i] = ref_cond(CondE, mf[i]);
    return r;
  endfunction

  function automatic logic [LANES-1:0] ref_act();
    logic [LANES-1:0] a;
    logic [LANES-1:0] c;
    c = ref_condex();
    a = '0;
    if (vec_mode) a = c & lane_mask_e & {LANES{valid_e}};
    else a[0] = valid_e && c[0];
    return a;
  endfunction

  function automatic logic ref_red(input logic [LANES-1:0] a);
    logic r;
    if (!vec_mode) return ref_cond(CondE, mf[0]);
    if (!br_reduce) return |a;
    if (lane_mask_e == '0) return 1'b0;
    r = 1'b1;
    for (int i = 0; i < LANES; i++) if (lane_mask_e[i] && !a[i]) r = 1'b0;
    return r;
  endfunction

  function automatic logic ref_bt();
    return BranchE && valid_e && !flush_i && ref_red(ref_act());
  endfunction

  function automatic logic [4*LANES-1:0] mf_packed();
    logic [4*LANES-1:0] p;
    for (int i = 0; i < LANES; i++) p[4*i +: 4] = mf[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) mf[i] = FLAG_RST;
    mm = '0;
    sb.delete();
  endtask

  // Predicts the state after the coming edge from the inputs currently driven, then advances.
  task automatic tick();
    logic [LANES-1:0] a;
    logic r;
    a = ref_act();
    r = ref_red(a);
    if (!stall_i && !flush_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (a[i] && FlagWriteE[1]) mf[i][3:2] = ALUFlags[4*i+2 +: 2];
        if (a[i] && FlagWriteE[0]) mf[i][1:0] = ALUFlags[4*i +: 2];
      end
    end
    if (flush_i) mm = '0;
    else if (!stall_i) mm = {a, PCSrcE && (vec_mode ? r : a[0]), RegWriteE && (|a), MemWriteE && (|a), valid_e};
    sb.push_back(mm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_i = 0; flush_i = 0; valid_e = 0; vec_mode = 0; br_reduce = 0;
    PCSrcE = 0; RegWriteE = 0; MemWriteE = 0; BranchE = 0;
    FlagWriteE = 2'b00; CondE = 4'hE; lane_mask_e = '0; ALUFlags = '0;
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (FlagsQ !== 16'h4444) begin n_fail++; $display("FAIL reset_flags got %h exp %h", FlagsQ, 16'h4444); end
    n_chk++; if (m_vec !== '0) begin n_fail++; $display("FAIL reset_m got %b exp %b", m_vec, 8'b0); end
    rst = 1;
    // Make state non-trivial, then assert reset between edges.
    valid_e = 1; vec_mode = 1; lane_mask_e = 4'hF; CondE = 4'hE; FlagWriteE = 2'b11;
    ALUFlags = 16'hFFFF; RegWriteE = 1;
    tick();
    e = sb.pop_front();
    n_chk++; if (m_vec !== e) begin n_fail++; $display("FAIL pre_reset_m got %b exp %b", m_vec, e); end
    n_chk++; if (FlagsQ !== mf_packed()) begin n_fail++; $display("FAIL pre_reset_flags got %h exp %h", FlagsQ, mf_packed()); end
    #1 rst = 0;
    #1;
    n_chk++; if (FlagsQ !== 16'h4444) begin n_fail++; $display("FAIL async_reset_flags got %h exp %h", FlagsQ, 16'h4444); end
    n_chk++; if (m_vec !== '0) begin n_fail++; $display("FAIL async_reset_m got %b exp %b", m_vec, 8'b0); end
    model_reset();
    #1 rst = 1;
    idle_inputs();
  endtask

  task automatic test_scalar_eq();
    valid_e = 1; vec_mode = 0; CondE = 4'h0; RegWriteE = 1; lane_mask_e = 4'h0;
    #1;
    n_chk++; if (CondExE[0] !== 1'b1) begin n_fail++; $display("FAIL scalar_condex got %b exp 1", CondExE[0]); end
    tick();
    e = sb.pop_front();
    n_chk++; if (m_vec !== e) begin n_fail++; $display("FAIL scalar_eq_m got %b exp %b", m_vec, e); end
    n_chk++; if (RegWriteM !== 1'b1 || lane_en_m !== 4'b0001) begin n_fail++; $display("FAIL scalar_eq_rw got %b/%b exp 1/0001", RegWriteM, lane_en_m); end
    // Clear Z in lane 0 only (scalar write), then EQ must fail.
    CondE = 4'hE; RegWriteE = 0; FlagWriteE = 2'b10; ALUFlags = 16'h0000;
    tick();
    e = sb.pop_front();
    n_chk++; if (FlagsQ !== 16'h4440) begin n_fail++; $display("FAIL scalar_flagwr got %h exp %h", FlagsQ, 16'h4440); end
    CondE = 4'h0; RegWriteE = 1; FlagWriteE = 2'b00;
    tick();
    e = sb.pop_front();
    n_chk++; if (m_vec !== e) begin n_fail++; $display("FAIL scalar_ne_m got %b exp %b", m_vec, e); end
    n_chk++; if (RegWriteM !== 1'b0 || lane_en_m !== 4'b0000) begin n_fail++; $display("FAIL scalar_ne_rw got %b/%b exp 0/0000", RegWriteM, lane_en_m); end
    RegWriteE = 0;
  endtask

  task automatic test_vector_pred();
    vec_mode = 1; lane_mask_e = 4'hF; CondE = 4'hE; FlagWriteE = 2'b10; ALUFlags = 16'h0404;
    tick();
    e = sb.pop_front();
    n_chk++; if (FlagsQ !== mf_packed()) begin n_fail++; $display("FAIL vec_setup_flags got %h exp %h", FlagsQ, mf_packed()); end
    CondE = 4'h0; MemWriteE = 1; ALUFlags = 16'h8888;
    #1;
    n_chk++; if (CondExE !== 4'b0101) begin n_fail++; $display("FAIL vec_condex got %b exp 0101", CondExE); end
    tick();
    e = sb.pop_front();
    n_chk++; if (m_vec !== e) begin n_fail++; $display("FAIL vec_pred_m got %b exp %b", m_vec, e); end
    n_chk++; if (lane_en_m !== 4'b0101 || MemWriteM !== 1'b1) begin n_fail++; $display("FAIL vec_pred_en got %b/%b exp 0101/1", lane_en_m, MemWriteM); end
    n_chk++; if (FlagsQ !== 16'h0808) begin n_fail++; $display("FAIL vec_pred_flags got %h exp %h", FlagsQ, 16'h0808); end
    n_chk++; if (CondExE !== 4'b0000) begin n_fail++; $display("FAIL vec_next_condex got %b exp 0000", CondExE); end
    MemWriteE = 0; FlagWriteE = 2'b00;
  endtask

  task automatic test_branch();
    CondE = 4'hE; FlagWriteE = 2'b10; ALUFlags = 16'h0440; lane_mask_e = 4'hF;
    tick();
    e = sb.pop_front();
    FlagWriteE = 2'b00; CondE = 4'h0; BranchE = 1; br_reduce = 0;
    #1;
    n_chk++; if (CondExE !== 4'b0110) begin n_fail++; $display("FAIL br_condex got %b exp 0110", CondExE); end
    n_chk++; if (BranchTakenE !== 1'b1) begin n_fail++; $display("FAIL br_any got %b exp 1", BranchTakenE); end
    br_reduce = 1;
    #1;
    n_chk++; if (BranchTakenE !== 1'b0) begin n_fail++; $display("FAIL br_all got %b exp 0", BranchTakenE); end
    lane_mask_e = 4'h0;
    #1;
    n_chk++; if (BranchTakenE !== 1'b0) begin n_fail++; $display("FAIL br_all_empty got %b exp 0", BranchTakenE); end
    lane_mask_e = 4'b0110; PCSrcE = 1;
    #1;
    n_chk++; if (BranchTakenE !== 1'b1) begin n_fail++; $display("FAIL br_all_masked got %b exp 1", BranchTakenE); end
    tick();
    e = sb.pop_front();
    n_chk++; if (m_vec !== e) begin n_fail++; $display("FAIL br_pcsrc_m got %b exp %b", m_vec, e); end
    n_chk++; if (PCSrcM !== 1'b1) begin n_fail++; $display("FAIL br_pcsrc got %b exp 1", PCSrcM); end
  endtask

  task automatic test_stall_flush();
    stall_i = 1; FlagWriteE = 2'b11; CondE = 4'hE; ALUFlags = 16'hFFFF; lane_mask_e = 4'hF;
    RegWriteE = 1; MemWriteE = 1; PCSrcE = 0;
    tick();
    e = sb.pop_front();
    n_chk++; if (m_vec !== e) begin n_fail++; $display("FAIL stall_hold_m got %b exp %b", m_vec, e); end
    n_chk++; if (FlagsQ !== 16'h0440) begin n_fail++; $display("FAIL stall_flags got %h exp %h", FlagsQ, 16'h0440); end
    flush_i = 1; BranchE = 1;
    #1;
    n_chk++; if (BranchTakenE !== 1'b0) begin n_fail++; $display("FAIL flush_branch got %b exp 0", BranchTakenE); end
    tick();
    e = sb.pop_front();
    n_chk++; if (m_vec !== '0) begin n_fail++; $display("FAIL flush_m got %b exp 00000000", m_vec); end
    n_chk++; if (FlagsQ !== 16'h0440) begin n_fail++; $display("FAIL flush_flags got %h exp %h", FlagsQ, 16'h0440); end
    stall_i = 0; flush_i = 0; BranchE = 0; RegWriteE = 0; MemWriteE = 0;
  endtask

  task automatic test_reserved_groups();
    CondE = 4'hF; FlagWriteE = 2'b11; ALUFlags = 16'hFFFF;
    #1;
    n_chk++; if (CondExE !== 4'b0000) begin n_fail++; $display("FAIL reserved_condex got %b exp 0000", CondExE); end
    tick();
    e = sb.pop_front();
    n_chk++; if (FlagsQ !== 16'h0440) begin n_fail++; $display("FAIL reserved_flags got %h exp %h", FlagsQ, 16'h0440); end
    n_chk++; if (m_vec !== e) begin n_fail++; $display("FAIL reserved_m got %b exp %b", m_vec, e); end
    CondE = 4'hE; FlagWriteE = 2'b01;
    tick();
    e = sb.pop_front();
    n_chk++; if (FlagsQ !== 16'h3773) begin n_fail++; $display("FAIL cv_only_flags got %h exp %h", FlagsQ, 16'h3773); end
    FlagWriteE = 2'b00;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 60; k++) begin
      stall_i = ($urandom_range(0, 4) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      valid_e = ($urandom_range(0, 5) != 0);
      vec_mode = $urandom_range(0, 1);
      br_reduce = $urandom_range(0, 1);
      PCSrcE = $urandom_range(0, 1);
      RegWriteE = $urandom_range(0, 1);
      MemWriteE = $urandom_range(0, 1);
      BranchE = $urandom_range(0, 1);
      FlagWriteE = 2'($urandom_range(0, 3));
      CondE = 4'($urandom_range(0, 15));
      lane_mask_e = 4'($urandom_range(0, 15));
      ALUFlags = 16'($urandom);
      #1;
      n_chk++; if (CondExE !== ref_condex()) begin n_fail++; $display("FAIL b2b_condex[%0d] got %b exp %b", k, CondExE, ref_condex()); end
      n_chk++; if (BranchTakenE !== ref_bt()) begin n_fail++; $display("FAIL b2b_branch[%0d] got %b exp %b", k, BranchTakenE, ref_bt()); end
      tick();
      e = sb.pop_front();
      n_chk++; if (m_vec !== e) begin n_fail++; $display("FAIL b2b_m[%0d] got %b exp %b", k, m_vec, e); end
      n_chk++; if (FlagsQ !== mf_packed()) begin n_fail++; $display("FAIL b2b_flags[%0d] got %h exp %h", k, FlagsQ, mf_packed()); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_scalar_eq();
    test_vector_pred();
    test_branch();
    test_stall_flush();
    test_reserved_groups();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conditional_unit_vec.md
Name: conditional_unit_vec

Overview:
- Parametrised successor to the scalar Execute-stage conditional unit, for the vector pipeline.
- Evaluates ARM-style 4-bit condition codes per lane against per-lane NZCV flag registers.
- Gates register, memory, PC and branch control per lane.
- Owns the Execute→Memory control pipeline register, with stall/flush and scalar/vector modes.

Parameters:
LANES, 4, number of vector lanes (1..16); each lane owns one NZCV flag set.
FLAG_RST, 4'b0000, reset value loaded into every lane's NZCV register.

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
stall_i  in  1  hold M-stage outputs; suppress flag writes
flush_i  in  1  kill instruction in E: M outputs cleared, flag writes and branch suppressed
valid_e  in  1  instruction in E is valid
vec_mode  in  1  0 = scalar (lane 0 only), 1 = vector (per-lane)
br_reduce  in  1  branch lane reduction: 0 = ANY, 1 = ALL
PCSrcE  in  1  instruction writes PC
RegWriteE  in  1  instruction writes register file
MemWriteE  in  1  instruction writes memory
BranchE  in  1  instruction is a branch
FlagWriteE  in  2  [1]=NZ write request, [0]=CV write request
CondE  in  4  condition code
lane_mask_e  in  LANES  active-lane mask from decode
ALUFlags  in  4*LANES  ALU NZCV per lane; lane i at [4i+3:4i], order N,Z,C,V
FlagsQ  out  4*LANES  registered flags per lane, same packing (to decode/forwarding)
CondExE  out  LANES  combinational per-lane condition result
BranchTakenE  out  1  combinational branch-taken
lane_en_m  out  LANES  registered effective lane enables for M
PCSrcM  out  1  registered
RegWriteM  out  1  registered
MemWriteM  out  1  registered
valid_m  out  1  registered

Behaviour:
- Reset (rst=0, async):
  - every FlagsQ lane = FLAG_RST;
  - lane_en_m, PCSrcM, RegWriteM, MemWriteM, valid_m all = 0.
  - Reset mid-operation discards the E instruction; no partial flag write.
- Condition decode on lane flags {N,Z,C,V}:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V;
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V);
  - E AL 1; F = 0 (reserved, never executes).
- Flags used for evaluation are FlagsQ (registered, one-cycle visibility).
  - A flag write in cycle t affects CondExE from cycle t+1.
  - No internal bypass.
- Effective lane enable lane_act[i]:
  - vector mode: valid_e & lane_mask_e[i] & CondExE[i];
  - scalar mode: lane 0 = valid_e & CondExE[0]; lanes 1..LANES-1 = 0; lane_mask_e ignored.
  - CondExE always reports the raw per-lane result regardless of mode and mask.
- Flag writes (cycle-level):
  - wr_ok = !stall_i & !flush_i.
  - Lane i NZ (bits 3:2) loads ALUFlags NZ when FlagWriteE[1] & lane_act[i] & wr_ok.
  - Lane i CV (bits 1:0) loads ALUFlags CV when FlagWriteE[0] & lane_act[i] & wr_ok.
  - NZ and CV groups update independently; other lanes hold.
- BranchTakenE = BranchE & valid_e & !flush_i & R.
  - Scalar mode: R = CondExE[0].
  - Vector mode: R = OR(lane_act) for ANY, AND over masked lanes for ALL.
  - ALL with lane_mask_e = 0 gives R = 0.
- M register on rising edge, in priority order:
  - flush_i=1: all M outputs ← 0 (overrides stall).
  - else stall_i=1: all M outputs hold.
  - else capture:
    - lane_en_m ← lane_act; valid_m ← valid_e; any = OR(lane_act);
    - RegWriteM ← RegWriteE & any; MemWriteM ← MemWriteE & any;
    - PCSrcM ← PCSrcE & (scalar ? lane_act[0] : R).
- Latency: one cycle E→M for control outputs; zero cycles for CondExE and BranchTakenE.
- LANES=1: vec_mode has no effect; behaviour equals the scalar unit plus stall/flush.

Test Plan:
1. Reset: rst=0 mid-stream with FLAG_RST=4'b0100 → all FlagsQ lanes = 0100, all M outputs 0 asynchronously, before the next clk edge.
2. Scalar EQ: lane0 Z=1, CondE=0, RegWriteE=1, valid_e=1, vec_mode=0 → CondExE[0]=1, next cycle RegWriteM=1, lane_en_m=0001; with Z=0 → RegWriteM=0.
3. Vector predication, LANES=4:
   - setup: flags lanes Z=1,0,1,0, mask=1111, CondE=EQ, MemWriteE=1, FlagWriteE=2'b10, ALUFlags NZ=10 on all lanes;
   - required: lane_en_m=0101, MemWriteM=1;
   - required: NZ updated only in lanes 0,2; next-cycle CondExE=0000.
4. Branch reduction: CondExE=0110, mask=1111, BranchE=1 → ANY gives BranchTakenE=1, ALL gives 0; ALL with mask=0000 gives 0.
5. Stall then flush:
   - stall_i=1 with FlagWriteE=2'b11, cond true → FlagsQ unchanged, M outputs held;
   - stall_i=1 with flush_i=1 → M outputs cleared, BranchTakenE=0.
6. Reserved and independent groups:
   - CondE=F → CondExE=0000, no flag write;
   - FlagWriteE=2'b01 with ALUFlags=1111 → only C,V set; N,Z unchanged.
